// File: rtl/gpr_pkg.sv
// Shared types and helpers for the tiny16 general-purpose register file.
package gpr_pkg;

   typedef logic [1:0] sp_op_t;

   localparam sp_op_t SP_OP_NONE = 2'b00;
   localparam sp_op_t SP_OP_INC  = 2'b01;
   localparam sp_op_t SP_OP_DEC  = 2'b10;
   localparam sp_op_t SP_OP_RSVD = 2'b11;

   // Register-index width; never narrower than one bit.
   function automatic int idx_w(input int nregs);
      return (nregs <= 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/gpr_sp_unit.sv
// Combinational stack-pointer adjust: next SP value and wrap detect for inc/dec.
module gpr_sp_unit
   import gpr_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SP_STEP = 1
) (
   input  logic [WIDTH-1:0] sp_i,
   input  logic [1:0]       sp_op_i,
   output logic [WIDTH-1:0] sp_next_o,
   output logic             wrap_o,
   output logic             active_o
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(SP_STEP);

   // One extra bit catches carry-out on inc and borrow on dec.
   logic [WIDTH:0] inc_x;
   logic [WIDTH:0] dec_x;

   assign inc_x = {1'b0, sp_i} + STEP_X;
   assign dec_x = {1'b0, sp_i} - STEP_X;

   always_comb begin
      sp_next_o = sp_i;
      wrap_o    = 1'b0;
      active_o  = 1'b0;
      case (sp_op_t'(sp_op_i))
         SP_OP_INC: begin
            sp_next_o = inc_x[WIDTH-1:0];
            wrap_o    = inc_x[WIDTH];
            active_o  = 1'b1;
         end
         SP_OP_DEC: begin
            sp_next_o = dec_x[WIDTH-1:0];
            wrap_o    = dec_x[WIDTH];
            active_o  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/gpr_file_sp.sv
// Register file with hardware stack pointer, two registered read ports and a bus-output port.
// Optional read-during-write bypass is enabled by defining GPR_BYPASS_EN.
module gpr_file_sp
   import gpr_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               NREGS    = 8,
   parameter int               SP_IDX   = 1,
   parameter logic [WIDTH-1:0] SP_RESET = '1,
   parameter int               SP_STEP  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [idx_w(NREGS)-1:0]   src_sel,
   input  logic [idx_w(NREGS)-1:0]   dst_sel,
   input  logic                      in_en,
   input  logic [WIDTH-1:0]          in,
   input  logic [1:0]                sp_op,
   input  logic                      out_en,
   output logic [WIDTH-1:0]          out,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          src,
   output logic [WIDTH-1:0]          dst,
   output logic                      sp_wrap
);

   localparam int IW = idx_w(NREGS);

   logic [WIDTH-1:0] gpr_rd [NREGS];

   logic [WIDTH-1:0] sp_next;
   logic             sp_wrap_c;
   logic             sp_active;
   logic             sp_wr_hit;
   logic             sp_apply;

   logic [WIDTH-1:0] src_q, src_d;
   logic [WIDTH-1:0] dst_q, dst_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q;
   logic             sp_wrap_q;

   gpr_sp_unit #(
      .WIDTH   (WIDTH),
      .SP_STEP (SP_STEP)
   ) u_sp (
      .sp_i      (gpr_rd[SP_IDX]),
      .sp_op_i   (sp_op),
      .sp_next_o (sp_next),
      .wrap_o    (sp_wrap_c),
      .active_o  (sp_active)
   );

   // An explicit write to the SP register suppresses that cycle's SP op.
   assign sp_wr_hit = in_en && (dst_sel == IW'(SP_IDX));
   assign sp_apply  = sp_active && !sp_wr_hit;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
         logic [WIDTH-1:0] reg_q;
         logic [WIDTH-1:0] reg_d;
         logic             wr_hit;

         assign wr_hit = in_en && (dst_sel == IW'(gi));

         if (gi == SP_IDX) begin : g_sp
            always_comb begin
               reg_d = reg_q;
               if (wr_hit) begin
                  reg_d = in;
               end else if (sp_apply) begin
                  reg_d = sp_next;
               end
            end
         end else begin : g_gp
            always_comb begin
               reg_d = reg_q;
               if (wr_hit) begin
                  reg_d = in;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               reg_q <= (gi == SP_IDX) ? SP_RESET : '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign gpr_rd[gi] = reg_q;
      end
   endgenerate

   // Indices beyond NREGS (non power-of-two sizes) read as zero.
   function automatic logic [WIDTH-1:0] rd_port(input logic [IW-1:0] idx);
      logic [WIDTH-1:0] v;
      v = '0;
      if (int'(idx) < NREGS) begin
         v = gpr_rd[idx];
`ifdef GPR_BYPASS_EN
         if (in_en && (idx == dst_sel)) begin
            v = in;
         end else if ((idx == IW'(SP_IDX)) && sp_apply) begin
            v = sp_next;
         end
`endif
      end
      return v;
   endfunction

   always_comb begin
      src_d = rd_port(src_sel);
      dst_d = rd_port(dst_sel);
      out_d = out_q;
      if (out_en) begin
         out_d = rd_port(src_sel);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q       <= '0;
         dst_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sp_wrap_q   <= 1'b0;
      end else begin
         src_q       <= src_d;
         dst_q       <= dst_d;
         out_q       <= out_d;
         out_valid_q <= out_en;
         sp_wrap_q   <= sp_apply && sp_wrap_c;
      end
   end

   assign src       = src_q;
   assign dst       = dst_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign sp_wrap   = sp_wrap_q;

endmodule
